// File: rtl/fpga_readback.sv
// fpga_readback
// Register readback responder. Accepts read commands from the master byte
// channel, snapshots the live register bus and queues framed response bytes
// ({4'h0, index} header followed by the data byte) in a show-ahead FIFO that
// the protocol front end drains with have_msg/len/rdreq.
//
// Ports:
//   clk, n_rst   clock, asynchronous active-low reset
//   master_data  command byte: bit 7 = read-all, else [3:0] = register index
//   valid        one-cycle strobe qualifying master_data
//   reg_bus      live register values, register i at [8i+7:8i]
//   rdreq        pop one byte from the response FIFO (ignored when empty)
//   have_msg     FIFO non-empty
//   slave_data   FIFO head byte, 0 when empty
//   len          number of bytes currently in the FIFO
//   busy         response generator active (not IDLE)
//   err_drop     one-cycle pulse the cycle after a rejected command
//   state_dbg    current FSM state encoding (observation only)
//
// Handshake: a command is taken only on a cycle with valid=1; there is no
// back-pressure, rejection is reported through err_drop. A byte leaves the
// FIFO on each clock edge where rdreq=1 and have_msg=1; slave_data always
// shows the head byte before that edge.

module fpga_readback #(
    parameter int N_REGS = 10,
    parameter int DEPTH  = 32
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [7:0]          master_data,
    input  logic                valid,
    input  logic [N_REGS*8-1:0] reg_bus,
    input  logic                rdreq,
    output logic                have_msg,
    output logic [7:0]          slave_data,
    output logic [7:0]          len,
    output logic                busy,
    output logic                err_drop,
    output logic [1:0]          state_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0] FREE_ONE = (AW+1)'(2);
    localparam logic [AW:0] FREE_ALL = (AW+1)'(2 * N_REGS);
    localparam logic [3:0]  LAST_IDX = 4'(N_REGS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [3:0]          cur_idx, cur_idx_next;
    logic                read_all, read_all_next;
    logic [N_REGS*8-1:0] snap;

    logic [7:0]          mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         count;
    logic [AW:0]         free_space;

    logic                cmd_all;
    logic [3:0]          cmd_idx;
    logic                idx_ok, space_ok, accept;
    logic                push, pop;
    logic [7:0]          push_data;

    // Bits [6:4] of the command carry no meaning.
    logic                unused_cmd_bits;
    assign unused_cmd_bits = ^master_data[6:4];

    assign cmd_all    = master_data[7];
    assign cmd_idx    = master_data[3:0];
    assign free_space = DEPTH_C - count;
    assign idx_ok     = int'(cmd_idx) < N_REGS;
    // Room for the whole response is reserved up front, so the FIFO can
    // never overflow while the FSM is emitting.
    assign space_ok   = cmd_all ? (free_space >= FREE_ALL) : (free_space >= FREE_ONE);
    assign accept     = valid && (state == IDLE) && space_ok && (cmd_all || idx_ok);
    assign pop        = rdreq && (count != '0);

    always_comb begin
        state_next    = state;
        cur_idx_next  = cur_idx;
        read_all_next = read_all;
        push          = 1'b0;
        push_data     = 8'h00;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next    = HDR;
                    cur_idx_next  = cmd_all ? 4'd0 : cmd_idx;
                    read_all_next = cmd_all;
                end
            end
            HDR: begin
                push       = 1'b1;
                push_data  = {4'h0, cur_idx};
                state_next = DATA;
            end
            DATA: begin
                push      = 1'b1;
                push_data = snap[{cur_idx, 3'b000} +: 8];
                if (read_all && (cur_idx < LAST_IDX)) begin
                    cur_idx_next = cur_idx + 4'd1;
                    state_next   = HDR;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            cur_idx  <= 4'd0;
            read_all <= 1'b0;
            snap     <= '0;
            err_drop <= 1'b0;
        end else begin
            state    <= state_next;
            cur_idx  <= cur_idx_next;
            read_all <= read_all_next;
            err_drop <= valid && !accept;
            // Snapshot the whole bus so a read-all reports one coherent instant.
            if (accept) begin
                snap <= reg_bus;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: slave_data is gated by the count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign have_msg   = (count != '0);
    assign slave_data = have_msg ? mem[rd_ptr] : 8'h00;
    assign len        = 8'(count);
    assign busy       = (state != IDLE);
    assign state_dbg  = state;

endmodule

// File: tb/tb_fpga_readback.sv
// Testbench for fpga_readback: directed command sequences, a queue-based
// reference model checked on every falling edge, and literal expectations
// for the documented scenarios.

module tb_fpga_readback;

    localparam int N_REGS = 10;
    localparam int DEPTH  = 32;

    // ---------------- clock / reset ----------------
    logic                clk = 1'b0;
    logic                n_rst = 1'b0;
    logic [7:0]          master_data = 8'h00;
    logic                valid = 1'b0;
    logic [N_REGS*8-1:0] reg_bus = '0;
    logic                rdreq = 1'b0;
    logic                have_msg;
    logic [7:0]          slave_data;
    logic [7:0]          len;
    logic                busy;
    logic                err_drop;
    logic [1:0]          state_dbg;

    always #5 clk = ~clk;

    fpga_readback #(.N_REGS(N_REGS), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .master_data (master_data),
        .valid       (valid),
        .reg_bus     (reg_bus),
        .rdreq       (rdreq),
        .have_msg    (have_msg),
        .slave_data  (slave_data),
        .len         (len),
        .busy        (busy),
        .err_drop    (err_drop),
        .state_dbg   (state_dbg)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // exp_q holds the bytes the FIFO must contain; pend_q holds the bytes of
    // an accepted command not yet written (one is written per clock).
    logic [7:0] exp_q[$];
    logic [7:0] pend_q[$];
    logic       exp_err = 1'b0;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            exp_q.delete();
            pend_q.delete();
            exp_err = 1'b0;
        end else begin
            int  free;
            bit  ok;
            int  idx;
            free = DEPTH - exp_q.size();
            ok   = 1'b0;
            idx  = int'(master_data[3:0]);
            if (valid && pend_q.size() == 0) begin
                if (master_data[7]) ok = (free >= 2 * N_REGS);
                else                ok = (idx < N_REGS) && (free >= 2);
            end
            if (rdreq && exp_q.size() > 0) void'(exp_q.pop_front());
            if (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
            if (ok) begin
                int lo, hi;
                lo = master_data[7] ? 0 : idx;
                hi = master_data[7] ? N_REGS - 1 : idx;
                for (int i = lo; i <= hi; i++) begin
                    pend_q.push_back(8'(i));
                    pend_q.push_back(reg_bus[8*i +: 8]);
                end
            end
            exp_err = valid && !ok;
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        check("model_have_msg", have_msg, exp_q.size() != 0);
        check("model_len", len, exp_q.size());
        check("model_slave_data", slave_data, (exp_q.size() != 0) ? exp_q[0] : 8'h00);
        check("model_busy", busy, pend_q.size() != 0);
        check("model_err_drop", err_drop, exp_err);
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_cmd(input logic [7:0] c);
        master_data = c;
        valid       = 1'b1;
        step(1);
        valid       = 1'b0;
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp);
        check(name, slave_data, exp);
        rdreq = 1'b1;
        step(1);
        rdreq = 1'b0;
    endtask

    task automatic load_regs(input logic [7:0] seed);
        for (int i = 0; i < N_REGS; i++) begin
            reg_bus[8*i +: 8] = seed ^ 8'(i * 19);
        end
    endtask

    task automatic fill_singles(input int n);
        for (int i = 0; i < n; i++) begin
            send_cmd(8'(i % N_REGS));
            step(2);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        logic [7:0] snap_v [N_REGS];
        logic [7:0] got[$];
        int         bc;
        int         max_len;

        // Reset values
        step(2);
        check("rst_have_msg", have_msg, 0);
        check("rst_slave_data", slave_data, 0);
        check("rst_len", len, 0);
        check("rst_busy", busy, 0);
        check("rst_err_drop", err_drop, 0);
        n_rst = 1'b1;
        step(2);

        // Single read of register 3
        load_regs(8'h40);
        reg_bus[8*3 +: 8] = 8'hA5;
        send_cmd(8'h03);
        check("single_busy", busy, 1);
        step(2);
        check("single_len", len, 2);
        check("single_busy_done", busy, 0);
        pop_check("single_hdr", 8'h03);
        pop_check("single_data", 8'hA5);
        check("single_empty_have_msg", have_msg, 0);
        check("single_empty_data", slave_data, 0);

        // Read-all coherency: bus changes during the burst must not leak in
        load_regs(8'h5C);
        for (int i = 0; i < N_REGS; i++) snap_v[i] = reg_bus[8*i +: 8];
        send_cmd(8'h80);
        bc = 0;
        while (busy && bc < 40) begin
            bc++;
            reg_bus = {$urandom, $urandom, $urandom};
            step(1);
        end
        check("readall_busy_cycles", bc, 20);
        check("readall_len", len, 20);
        for (int j = 0; j < 2 * N_REGS; j++) begin
            pop_check("readall_byte", (j % 2 == 0) ? 8'(j / 2) : snap_v[j / 2]);
        end
        check("readall_drained", len, 0);

        // Reject: index out of range (bits [6:4] set to show they are ignored)
        send_cmd(8'h7C);
        check("rej_idx_err", err_drop, 1);
        check("rej_idx_len", len, 0);
        step(1);
        check("rej_idx_err_clear", err_drop, 0);

        // Ignored bits [6:4]: 0x75 reads register 5
        load_regs(8'h21);
        send_cmd(8'h75);
        step(2);
        pop_check("ign_bits_hdr", 8'h05);
        pop_check("ign_bits_data", 8'h21 ^ 8'(5 * 19));

        // Reject: second command while busy
        send_cmd(8'h01);
        send_cmd(8'h02);
        check("rej_busy_err", err_drop, 1);
        check("rej_busy_len", len, 1);
        step(1);
        check("rej_busy_err_once", err_drop, 0);
        check("rej_busy_len_after", len, 2);
        rdreq = 1'b1;
        step(2);
        rdreq = 1'b0;

        // Reject: read-all with 15 bytes queued (17 free < 20)
        fill_singles(8);
        rdreq = 1'b1;
        step(1);
        rdreq = 1'b0;
        check("prefill_len15", len, 15);
        send_cmd(8'h80);
        check("rej_space_err", err_drop, 1);
        check("rej_space_len", len, 15);
        step(1);
        check("rej_space_err_once", err_drop, 0);

        // Boundary: exactly 20 free accepts a read-all and fills the FIFO
        rdreq = 1'b1;
        step(3);
        rdreq = 1'b0;
        check("boundary_len12", len, 12);
        send_cmd(8'h80);
        check("boundary_accept_no_err", err_drop, 0);
        step(20);
        check("boundary_full_len", len, 32);
        check("boundary_full_busy", busy, 0);
        send_cmd(8'h01);
        check("rej_full_err", err_drop, 1);
        rdreq = 1'b1;
        step(32);
        rdreq = 1'b0;
        check("full_drained", len, 0);

        // Empty pops are ignored
        for (int i = 0; i < 3; i++) begin
            rdreq = 1'b1;
            step(1);
            rdreq = 1'b0;
            step(1);
        end
        check("empty_pop_len", len, 0);
        check("empty_pop_have_msg", have_msg, 0);

        // Simultaneous push/pop across pointer wrap
        fill_singles(15);
        check("wrap_prefill_len", len, 30);
        rdreq = 1'b1;
        step(30);
        check("wrap_drain_len", len, 0);
        load_regs(8'h9E);
        for (int i = 0; i < N_REGS; i++) snap_v[i] = reg_bus[8*i +: 8];
        send_cmd(8'h80);
        max_len = 0;
        for (int t = 0; t < 24; t++) begin
            if (int'(len) > max_len) max_len = int'(len);
            if (have_msg) got.push_back(slave_data);
            step(1);
        end
        rdreq = 1'b0;
        check("stream_max_len", max_len, 1);
        check("stream_count", got.size(), 20);
        for (int j = 0; j < got.size() && j < 2 * N_REGS; j++) begin
            check("stream_byte", got[j], (j % 2 == 0) ? 8'(j / 2) : snap_v[j / 2]);
        end

        // Reset in the middle of a read-all
        send_cmd(8'h80);
        step(4);
        @(posedge clk);
        #1;
        n_rst = 1'b0;
        #1;
        check("midrst_have_msg", have_msg, 0);
        check("midrst_slave_data", slave_data, 0);
        check("midrst_len", len, 0);
        check("midrst_busy", busy, 0);
        check("midrst_err_drop", err_drop, 0);
        step(2);
        n_rst = 1'b1;
        step(1);
        load_regs(8'h33);
        send_cmd(8'h05);
        step(2);
        check("postrst_len", len, 2);
        step(3);
        check("postrst_len_stable", len, 2);
        check("postrst_busy", busy, 0);
        pop_check("postrst_hdr", 8'h05);
        pop_check("postrst_data", 8'h33 ^ 8'(5 * 19));
        check("postrst_empty", len, 0);

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
